// File: rtl/crc32_share_arb.sv
// crc32_share_arb
//   One bit-serial CRC-32 engine shared between NREQ byte-stream requesters.
//   A requester is chosen round-robin and keeps the engine for a whole
//   packet; each finished packet yields one tagged result word.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [NREQ]    byte valid per requester
//   req_last   in   [NREQ]    final byte of the packet
//   req_data   in   [8*NREQ]  requester k drives bits [8k+7:8k]
//   req_ready  out  [NREQ]    byte taken on valid & ready
//   res_valid  out            result available
//   res_id     out  [2]       requester index of the result
//   res_crc    out  [32]      final CRC (crc_reg ^ XOROUT)
//   res_ready  in             result taken on valid & ready
//   busy       out            engine not idle
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready and res_valid are decoded from registered state only,
// never from the matching valid/ready input.

module crc32_share_arb #(
    parameter int          NREQ   = 2,
    parameter logic [31:0] POLY   = 32'hEDB88320,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [1:0]        res_id,
    output logic [31:0]       res_crc,
    input  logic              res_ready,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [1:0]  state;
    logic [1:0]  rr_ptr;
    logic [1:0]  grant;
    logic [31:0] crc_reg;
    logic [2:0]  bit_cnt;
    logic        last_q;

    // Requester lanes padded to the maximum of four so that a 2-bit index
    // can address them for any legal NREQ.
    logic [3:0]  valid4;
    logic [3:0]  last4;
    logic [31:0] data4;

    for (genvar k = 0; k < 4; k++) begin : g_pad
        if (k < NREQ) begin : g_lane
            assign valid4[k]        = req_valid[k];
            assign last4[k]         = req_last[k];
            assign data4[8*k +: 8]  = req_data[8*k +: 8];
        end else begin : g_none
            assign valid4[k]        = 1'b0;
            assign last4[k]         = 1'b0;
            assign data4[8*k +: 8]  = 8'h00;
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_ready
        assign req_ready[k] = (state == S_ACCEPT) && (grant == 2'(k));
    end

    // Round-robin pick: scan offsets from the highest down so the lowest
    // offset from rr_ptr that holds valid is the one left in pick.
    logic [1:0] pick;
    logic       any_valid;
    logic [2:0] sum;

    always_comb begin
        pick      = rr_ptr;
        any_valid = 1'b0;
        sum       = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + 3'(i);
            if (sum >= 3'(NREQ)) begin
                sum = sum - 3'(NREQ);
            end
            if (valid4[sum[1:0]]) begin
                pick      = sum[1:0];
                any_valid = 1'b1;
            end
        end
    end

    // Byte, valid and last of the lane currently holding the grant.
    logic       g_valid;
    logic       g_last;
    logic [7:0] g_data;

    always_comb begin
        g_valid = valid4[grant];
        g_last  = last4[grant];
        case (grant)
            2'd0:    g_data = data4[7:0];
            2'd1:    g_data = data4[15:8];
            2'd2:    g_data = data4[23:16];
            default: g_data = data4[31:24];
        endcase
    end

    logic [1:0] grant_inc;
    assign grant_inc = (grant == 2'(NREQ - 1)) ? 2'd0 : grant + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rr_ptr  <= 2'd0;
            grant   <= 2'd0;
            crc_reg <= INIT;
            bit_cnt <= 3'd0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant   <= pick;
                        crc_reg <= INIT;
                        state   <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    // Grant stays locked while the owner idles between bytes.
                    if (g_valid) begin
                        crc_reg <= crc_reg ^ {24'h0, g_data};
                        last_q  <= g_last;
                        bit_cnt <= 3'd0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    crc_reg <= crc_reg[0] ? ((crc_reg >> 1) ^ POLY) : (crc_reg >> 1);
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= last_q ? S_RESULT : S_ACCEPT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        rr_ptr <= grant_inc;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign res_valid = (state == S_RESULT);
    assign res_id    = res_valid ? grant : 2'd0;
    assign res_crc   = res_valid ? (crc_reg ^ XOROUT) : 32'h0;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_crc32_share_arb.sv
// tb_crc32_share_arb
//   Directed and randomized bench for crc32_share_arb (NREQ = 2).
//   Byte lanes are fed from per-lane queues; a reference model predicts the
//   round-robin service order and the table-driven CRC of every packet.

module tb_crc32_share_arb;

    localparam int          NREQ   = 2;
    localparam logic [31:0] POLY   = 32'hEDB88320;
    localparam logic [31:0] INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] XOROUT = 32'hFFFFFFFF;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [1:0]        res_id;
    logic [31:0]       res_crc;
    logic              res_ready;
    logic              busy;

    crc32_share_arb #(
        .NREQ(NREQ), .POLY(POLY), .INIT(INIT), .XOROUT(XOROUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .res_valid(res_valid), .res_id(res_id), .res_crc(res_crc),
        .res_ready(res_ready), .busy(busy)
    );

    // bench state
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    logic [8:0]  lane_q [NREQ][$];   // {last, byte}
    logic        hold   [NREQ];
    logic [33:0] exp_q[$];           // {id, crc}
    bit          model_idle = 1'b1;
    int          model_rr   = 0;
    int          model_grant = 0;
    int          hs_cnt [NREQ];
    int          hs_time1[$];
    logic [1:0]  res_log[$];
    logic [31:0] crc_log[$];
    logic [31:0] last_crc;
    int          res_cnt = 0;
    logic [31:0] crc_tab [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void build_tab();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
            crc_tab[i] = c;
        end
    endfunction

    // CRC of the packet at the head of lane k's queue.
    function automatic logic [31:0] ref_crc(input int k);
        logic [31:0] c = INIT;
        for (int i = 0; i < lane_q[k].size(); i++) begin
            c = (c >> 8) ^ crc_tab[c[7:0] ^ lane_q[k][i][7:0]];
            if (lane_q[k][i][8]) break;
        end
        return c ^ XOROUT;
    endfunction

    function automatic logic [31:0] crc_str(input string s);
        logic [31:0] c = INIT;
        for (int i = 0; i < s.len(); i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ 8'(s[i])];
        return c ^ XOROUT;
    endfunction

    // driver tasks
    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (lane_q[k].size() > 0) begin
                req_valid[k]       = !hold[k];
                req_data[8*k +: 8] = lane_q[k][0][7:0];
                req_last[k]        = lane_q[k][0][8];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[8*k +: 8] = 8'($urandom);
                req_last[k]        = 1'($urandom);
            end
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input logic last);
        lane_q[k].push_back({last, b});
    endtask

    task automatic push_str(input int k, input string s);
        for (int i = 0; i < s.len(); i++) push_byte(k, 8'(s[i]), i == s.len() - 1);
    endtask

    // One clock: check and update the model against pre-edge values, then
    // advance past the edge and retire accepted bytes.
    task automatic tick();
        logic [NREQ-1:0] hs;
        logic [NREQ-1:0] allowed;
        logic            rhs;
        logic            rst_s;
        logic [33:0]     e;
        int              idx;
        rst_s = rst;
        hs    = req_valid & req_ready;
        rhs   = res_valid & res_ready;
        if (!rst_s) begin
            chk("busy", busy, !model_idle);
            allowed = '0;
            if (!model_idle) allowed[model_grant] = 1'b1;
            chk("ready_mask", req_ready & ~allowed, 0);
            if (rhs) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_id", res_id, e[33:32]);
                    chk("res_crc", res_crc, e[31:0]);
                    model_rr = (int'(e[33:32]) + 1) % NREQ;
                end
                res_log.push_back(res_id);
                crc_log.push_back(res_crc);
                last_crc = res_crc;
                res_cnt++;
            end
            if (model_idle && (|req_valid)) begin
                for (int i = NREQ - 1; i >= 0; i--) begin
                    idx = (model_rr + i) % NREQ;
                    if (req_valid[idx]) model_grant = idx;
                end
                exp_q.push_back({2'(model_grant), ref_crc(model_grant)});
                model_idle = 1'b0;
            end
            if (rhs) model_idle = 1'b1;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (rst_s) begin
            model_idle = 1'b1;
            model_rr   = 0;
            exp_q.delete();
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (hs[k]) begin
                    void'(lane_q[k].pop_front());
                    hs_cnt[k]++;
                    if (k == 1) hs_time1.push_back(cycle);
                end
            end
        end
        drive();
    endtask

    task automatic wait_results(input int n, input int budget, input string tag);
        int t = 0;
        int target = res_cnt + n;
        while (res_cnt < target && t < budget) begin
            tick();
            t++;
        end
        chk(tag, res_cnt >= target, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        res_ready = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            lane_q[k].delete();
            hold[k] = 1'b0;
        end
        drive();
        tick();
        tick();
        rst = 1'b0;
        drive();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base;
        int bad;
        bit seen;
        bit stable;
        logic [31:0] snap_crc;
        logic [1:0]  snap_id;
        logic [7:0]  pb;
        int          pk;
        int          plen;

        build_tab();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int k = 0; k < NREQ; k++) hs_cnt[k] = 0;
        do_reset();

        // reset values
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_crc", res_crc, 0);

        // single-byte packet 0x00 on lane 0
        push_byte(0, 8'h00, 1'b1);
        drive();
        chk("t1_ready_before_grant", req_ready, 0);
        tick();
        chk("t1_ready_after_grant", req_ready, 2'b01);
        tick();
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t1_result_latency", n, 8);
        chk("t1_crc", res_crc, 32'hD202EF8D);
        chk("t1_id", res_id, 0);
        res_ready = 1'b1;
        tick();
        chk("t1_idle_after", busy, 0);

        // "123456789" on lane 1 with res_ready high
        hs_time1.delete();
        push_str(1, "123456789");
        drive();
        wait_results(1, 200, "t2_done");
        chk("t2_crc", last_crc, 32'hCBF43926);
        chk("t2_id", res_log[res_log.size()-1], 1);
        chk("t2_hs_count", hs_time1.size(), 9);
        bad = 0;
        for (int i = 1; i < hs_time1.size(); i++) if (hs_time1[i] - hs_time1[i-1] != 9) bad++;
        chk("t2_hs_spacing", bad, 0);

        // both lanes from reset, then lane 0 re-requests
        do_reset();
        res_ready = 1'b1;
        push_str(0, "ab");
        push_str(1, "cd");
        drive();
        base = res_cnt;
        n = 0;
        seen = 1'b0;
        while (res_cnt == base && n < 100) begin
            tick();
            n++;
            if (req_ready[1]) seen = 1'b1;
        end
        chk("t3_first_id", res_log[res_log.size()-1], 0);
        chk("t3_no_ready1_during_p0", seen, 0);
        push_str(0, "ef");
        drive();
        wait_results(2, 200, "t3_rest");
        chk("t3_second_id", res_log[res_log.size()-2], 1);
        chk("t3_third_id", res_log[res_log.size()-1], 0);

        // result backpressure for 20 cycles with lane 1 waiting
        res_ready = 1'b0;
        push_byte(0, 8'h5A, 1'b1);
        drive();
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        chk("t4_reach_result", res_valid, 1);
        snap_crc = res_crc;
        snap_id  = res_id;
        push_str(1, "xy");
        drive();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_crc !== snap_crc || res_id !== snap_id || req_ready !== 2'b00)
                stable = 1'b0;
        end
        chk("t4_stable", stable, 1);
        res_ready = 1'b1;
        tick();
        chk("t4_idle_next", busy, 0);
        wait_results(1, 100, "t4_drain");

        // valid gap between the two bytes of "12", lane 1 waiting
        push_str(0, "12");
        push_str(1, "zz");
        drive();
        base = hs_cnt[0];
        n = 0;
        while (hs_cnt[0] == base && n < 20) begin
            tick();
            n++;
        end
        hold[0] = 1'b1;
        drive();
        seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (req_ready[1]) seen = 1'b1;
        end
        chk("t5_no_ready1", seen, 0);
        chk("t5_grant_held", req_ready, 2'b01);
        hold[0] = 1'b0;
        drive();
        wait_results(2, 200, "t5_done");
        chk("t5_first_id", res_log[res_log.size()-2], 0);
        chk("t5_crc", crc_log[crc_log.size()-2], crc_str("12"));

        // reset during SHIFT of byte 3
        push_str(0, "123456789");
        drive();
        base = hs_cnt[0];
        n = 0;
        while (hs_cnt[0] < base + 3 && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < NREQ; k++) lane_q[k].delete();
        drive();
        tick();
        chk("t6_res_valid_after_rst", res_valid, 0);
        chk("t6_busy_after_rst", busy, 0);
        rst = 1'b0;
        drive();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        chk("t6_no_result", seen, 0);
        push_str(0, "123456789");
        drive();
        wait_results(1, 200, "t6_resend");
        chk("t6_crc", last_crc, 32'hCBF43926);

        // randomized packets, random gaps and result backpressure
        base = res_cnt;
        for (int p = 0; p < 12; p++) begin
            pk   = $urandom_range(0, NREQ - 1);
            plen = $urandom_range(1, 4);
            for (int i = 0; i < plen; i++) begin
                pb = 8'($urandom);
                push_byte(pk, pb, i == plen - 1);
            end
        end
        drive();
        n = 0;
        while ((lane_q[0].size() > 0 || lane_q[1].size() > 0 || exp_q.size() > 0) && n < 6000) begin
            res_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) hold[k] = ($urandom_range(0, 4) == 0);
            drive();
            tick();
            n++;
        end
        chk("rand_drained", (lane_q[0].size() == 0 && lane_q[1].size() == 0 && exp_q.size() == 0), 1);
        chk("rand_count", res_cnt - base, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
